// File: rtl/data_mem.sv
// Word-organised data memory for the MEM stage: combinational little-endian loads with
// zero/sign extension, byte/half/word stores on the rising edge, synchronous clear-all reset.
module data_mem #(
    parameter int WORDS = 3072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemWrite,
    input  logic [2:0]  DMop,
    output logic [31:0] rdata
);

    localparam int          AW      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [29:0] WORDS_W = 30'(WORDS);

    logic [31:0]   mem_r [WORDS] = '{default: 32'h0000_0000};

    logic [29:0]   word_idx_s;
    logic [AW-1:0] idx_s;
    logic          in_range_s;
    logic          valid_op_s;
    logic          aligned_s;
    logic          access_ok_s;
    logic          write_en_s;
    logic [31:0]   cur_word_s;
    logic [15:0]   half_s;
    logic [7:0]    byte_s;
    logic [31:0]   load_s;
    logic [31:0]   merged_s;

    assign word_idx_s  = addr[31:2];
    assign idx_s       = word_idx_s[AW-1:0];
    // Range test uses the full 30-bit index so high addresses never alias onto low words.
    assign in_range_s  = (word_idx_s < WORDS_W);
    assign cur_word_s  = in_range_s ? mem_r[idx_s] : 32'h0000_0000;
    assign access_ok_s = in_range_s & valid_op_s & aligned_s;
    assign write_en_s  = MemWrite & access_ok_s;
    assign half_s      = addr[1] ? cur_word_s[31:16] : cur_word_s[15:0];
    assign byte_s      = cur_word_s[{addr[1:0], 3'b000} +: 8];
    assign rdata       = load_s;

    // Access-size decode and alignment check.
    always_comb begin
        valid_op_s = 1'b0;
        aligned_s  = 1'b0;
        case (DMop)
            3'b000: begin
                valid_op_s = 1'b1;
                aligned_s  = (addr[1:0] == 2'b00);
            end
            3'b001, 3'b010: begin
                valid_op_s = 1'b1;
                aligned_s  = ~addr[0];
            end
            3'b011, 3'b100: begin
                valid_op_s = 1'b1;
                aligned_s  = 1'b1;
            end
            default: begin
                valid_op_s = 1'b0;
                aligned_s  = 1'b0;
            end
        endcase
    end

    // Load path: lane select and extension; any rejected access reads as zero.
    always_comb begin
        load_s = 32'h0000_0000;
        if (access_ok_s) begin
            case (DMop)
                3'b000:  load_s = cur_word_s;
                3'b001:  load_s = {16'h0000, half_s};
                3'b010:  load_s = {{16{half_s[15]}}, half_s};
                3'b011:  load_s = {24'h00_0000, byte_s};
                3'b100:  load_s = {{24{byte_s[7]}}, byte_s};
                default: load_s = 32'h0000_0000;
            endcase
        end else begin
            load_s = 32'h0000_0000;
        end
    end

    // Store merge: sub-word stores overwrite one lane of the current word, signedness ignored.
    always_comb begin
        merged_s = cur_word_s;
        case (DMop)
            3'b000: merged_s = wdata;
            3'b001, 3'b010: begin
                if (addr[1]) begin
                    merged_s[31:16] = wdata[15:0];
                end else begin
                    merged_s[15:0] = wdata[15:0];
                end
            end
            3'b011, 3'b100: merged_s[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
            default: merged_s = cur_word_s;
        endcase
    end

    // Storage update: reset clears every word and wins over a simultaneous store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (write_en_s) begin
            mem_r[idx_s] <= merged_s;
        end
    end

`ifndef SYNTHESIS
    // Store trace for co-simulation against the reference model.
    always_ff @(posedge clk) begin
        if (!reset && write_en_s) begin
            $display("@%08h: *%08h <= %08h", PC, {addr[31:2], 2'b00}, merged_s);
        end
    end
`endif

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: byte-addressed reference model checked every cycle,
// plus hand-computed literal expectations at the key points.
module tb_data_mem;

    localparam int WORDS = 3072;

    logic        clk;
    logic        reset;
    logic [31:0] PC;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        MemWrite;
    logic [2:0]  DMop;
    logic [31:0] rdata;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] mb [WORDS*4];

    data_mem #(.WORDS(WORDS)) dut (
        .clk      (clk),
        .reset    (reset),
        .PC       (PC),
        .addr     (addr),
        .wdata    (wdata),
        .MemWrite (MemWrite),
        .DMop     (DMop),
        .rdata    (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int op_size(input logic [2:0] op);
        case (op)
            3'd0:       return 4;
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 0;
        endcase
    endfunction

    function automatic bit model_ok(input logic [31:0] a, input logic [2:0] op);
        longint unsigned ua;
        int sz;
        ua = longint'(a);
        sz = op_size(op);
        if (sz == 0) return 1'b0;
        if ((ua / 4) >= longint'(WORDS)) return 1'b0;
        if ((ua % longint'(sz)) != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] op);
        longint unsigned v;
        longint unsigned ua;
        int sz;
        if (!model_ok(a, op)) return 32'h0;
        ua = longint'(a);
        sz = op_size(op);
        v  = 0;
        for (int i = 0; i < sz; i++) v = v | (longint'(mb[int'(ua) + i]) << (8 * i));
        if ((op == 3'd2 || op == 3'd4) && (((v >> (8 * sz - 1)) & 1) == 1))
            v = v | ~((64'd1 << (8 * sz)) - 1);
        return v[31:0];
    endfunction

    initial begin
        for (int i = 0; i < WORDS * 4; i++) mb[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS * 4; i++) mb[i] <= 8'h00;
        end else if (MemWrite && model_ok(addr, DMop)) begin
            for (int i = 0; i < op_size(DMop); i++)
                mb[int'(addr) + i] <= 8'(wdata >> (8 * i));
        end
    end

    // Every cycle: the load result must match the model's view of current storage.
    always @(negedge clk) begin
        logic [31:0] exp_v;
        exp_v = model_read(addr, DMop);
        vectors++;
        if (rdata !== exp_v) begin
            miscompares++;
            $display("FAIL model addr=%08h op=%0d: got %08h want %08h", addr, DMop, rdata, exp_v);
        end
    end

    task automatic drive(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] wd,
                         input logic mw, input logic [2:0] op, input logic rst);
        @(posedge clk);
        #1;
        PC       = pc;
        addr     = a;
        wdata    = wd;
        MemWrite = mw;
        DMop     = op;
        reset    = rst;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] op);
        drive(32'h0000_3000, a, wd, 1'b1, op, 1'b0);
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] op);
        drive(32'h0000_3000, a, 32'h0, 1'b0, op, 1'b0);
    endtask

    task automatic lit(input string name, input logic [31:0] exp_v);
        #3;
        vectors++;
        if (rdata !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %08h want %08h", name, rdata, exp_v);
        end
    endtask

    initial begin
        PC = 32'h0; addr = 32'h10; wdata = 32'h0; MemWrite = 1'b0; DMop = 3'd0; reset = 1'b0;
        ld(32'h10, 3'd0);                lit("time0_zero", 32'h0000_0000);
        drive(32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b1);
        drive(32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b1);

        st(32'h10, 32'h1234_5678, 3'd0);
        ld(32'h10, 3'd0);                lit("word_load", 32'h1234_5678);
        st(32'h13, 32'hFFFF_FFAB, 3'd3);
        ld(32'h10, 3'd0);                lit("byte_merge", 32'hAB34_5678);
        ld(32'h13, 3'd4);                lit("byte_sext", 32'hFFFF_FFAB);
        ld(32'h13, 3'd3);                lit("byte_zext", 32'h0000_00AB);

        st(32'h22, 32'hFFFF_8001, 3'd1);
        ld(32'h20, 3'd0);                lit("half_merge", 32'h8001_0000);
        ld(32'h22, 3'd2);                lit("half_sext", 32'hFFFF_8001);
        ld(32'h20, 3'd1);                lit("half_zext_low", 32'h0000_0000);

        st(32'h0E, 32'hDEAD_BEEF, 3'd0);
        ld(32'h0C, 3'd0);                lit("misalign_no_write", 32'h0000_0000);
        ld(32'h0E, 3'd0);                lit("misalign_load", 32'h0000_0000);
        ld(32'h10, 3'd0);                lit("misalign_neighbour", 32'hAB34_5678);
        st(WORDS * 4, 32'hDEAD_BEEF, 3'd0);
        ld(WORDS * 4, 3'd0);             lit("oob_load", 32'h0000_0000);
        st(32'h8000_0000, 32'hDEAD_BEEF, 3'd0);
        ld(32'h0, 3'd0);                 lit("oob_no_alias", 32'h0000_0000);
        st(32'h30, 32'hDEAD_BEEF, 3'd5);
        ld(32'h30, 3'd0);                lit("bad_op_no_write", 32'h0000_0000);
        ld(32'h10, 3'd7);                lit("bad_op_load", 32'h0000_0000);
        st(32'h11, 32'h0000_5555, 3'd2);
        ld(32'h10, 3'd0);                lit("misalign_half", 32'hAB34_5678);

        st(32'h40, 32'h0000_0011, 3'd3);
        st(32'h41, 32'h0000_0022, 3'd4);
        st(32'h42, 32'h0000_0033, 3'd3);
        st(32'h43, 32'h0000_0044, 3'd4);
        ld(32'h40, 3'd0);                lit("all_lanes", 32'h4433_2211);
        st(32'h40, 32'h1234_BEEF, 3'd2);
        ld(32'h40, 3'd0);                lit("half_low_merge", 32'h4433_BEEF);
        ld(32'h41, 3'd4);                lit("byte1_sext", 32'hFFFF_FFBE);
        ld(32'h42, 3'd1);                lit("half_hi_zext", 32'h0000_4433);

        st(32'h10, 32'hCAFE_F00D, 3'd0); lit("rdw_old", 32'hAB34_5678);
        ld(32'h10, 3'd0);                lit("rdw_new", 32'hCAFE_F00D);
        st((WORDS - 1) * 4, 32'h8765_4321, 3'd0);
        ld((WORDS - 1) * 4, 3'd0);       lit("last_word", 32'h8765_4321);

        drive(32'h0000_3004, 32'h10, 32'h0000_0055, 1'b1, 3'd0, 1'b1);
        ld(32'h10, 3'd0);                lit("reset_clears", 32'h0000_0000);
        ld(32'h40, 3'd0);                lit("reset_clears_40", 32'h0000_0000);
        ld((WORDS - 1) * 4, 3'd0);       lit("reset_clears_last", 32'h0000_0000);
        for (int w = 0; w < WORDS; w++) ld(w * 4, 3'd0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
